alu_dp_sequencer: RTL and testbench

Sequencer that owns the ARM CPSR condition flags and drives the shared combinational ALU for one data-processing instruction at a time. It accepts a decoded request, evaluates the condition code, and issues the mapped 5-bit ALU opcode. It optionally iterates the ALU ADD for a 32-cycle shift-add MUL, then returns the result with a write-enable over a valid/ready handshake. It sits between the decode stage and register-file writeback.

---
 rtl/alu_seq_pkg.sv | 86 ++++++++
 rtl/cond_check.sv | 35 +++
 rtl/alu_dp_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alu_dp_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the data-processing sequencer: ALU opcodes, ARM opcodes
// and conditions, FSM state type and opcode classification helpers.
package alu_seq_pkg;

  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_EOR  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_RSB  = 5'b00011;
  localparam logic [4:0] ALU_ADD  = 5'b00100;
  localparam logic [4:0] ALU_ADC  = 5'b00101;
  localparam logic [4:0] ALU_SBC  = 5'b00110;
  localparam logic [4:0] ALU_RSC  = 5'b00111;
  localparam logic [4:0] ALU_TST  = 5'b01000;
  localparam logic [4:0] ALU_TEQ  = 5'b01001;
  localparam logic [4:0] ALU_CMP  = 5'b01010;
  localparam logic [4:0] ALU_CMN  = 5'b01011;
  localparam logic [4:0] ALU_ORR  = 5'b01100;
  localparam logic [4:0] ALU_MOV  = 5'b01101;
  localparam logic [4:0] ALU_BIC  = 5'b01110;
  localparam logic [4:0] ALU_MVN  = 5'b01111;
  localparam logic [4:0] ALU_IDLE = 5'b11111;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_arith(input logic [3:0] op);
    case (op)
      OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN: is_arith = 1'b1;
      default: is_arith = 1'b0;
    endcase
  endfunction

  // TST/TEQ/CMP/CMN: flags only, no register write.
  function automatic logic is_test(input logic [3:0] op);
    is_test = (op[3:2] == 2'b10);
  endfunction

  function automatic logic [4:0] map_op(input logic [3:0] op);
    case (op)
      OP_TST:  map_op = ALU_AND;
      OP_TEQ:  map_op = ALU_EOR;
      OP_CMP:  map_op = ALU_SUB;
      OP_CMN:  map_op = ALU_ADD;
      default: map_op = {1'b0, op};
    endcase
  endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluator; flags are {N,Z,C,V}. The NV encoding never passes.
module cond_check
  import alu_seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_dp_sequencer.sv
// Data-processing sequencer owning the NZCV flags and driving a shared ALU.
// Define ALU_SEQ_MUL_EN to build the 32-cycle shift-add MUL path.
module alu_dp_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [3:0]       reqCond,
  input  logic [3:0]       reqOp,
  input  logic             reqS,
  input  logic             reqMul,
  input  logic [WIDTH-1:0] reqA,
  input  logic [WIDTH-1:0] reqB,
  input  logic             reqShC,
  input  logic [3:0]       reqRd,
  output logic [WIDTH-1:0] aluA,
  output logic [WIDTH-1:0] aluB,
  output logic [4:0]       aluOpCode,
  output logic             aluCarryIn,
  input  logic [WIDTH-1:0] aluOut,
  input  logic             aluC,
  input  logic             aluV,
  output logic             respValid,
  input  logic             respReady,
  output logic [WIDTH-1:0] respResult,
  output logic [3:0]       respRd,
  output logic             respWe,
  output logic             respUndef,
  output logic [3:0]       flags,
  output logic [1:0]       dbgState
);

  // Handshakes: a request transfers on a cycle with reqValid && reqReady; a
  // response transfers on respValid && respReady and is held stable until then.

  state_t           state_q;
  logic [3:0]       op_q;
  logic             s_q;
  logic             shc_q;
  logic [WIDTH-1:0] opa_q;   // EXEC: operand A; MUL: accumulator
  logic [WIDTH-1:0] opb_q;   // EXEC: operand B; MUL: shifted multiplicand
  logic [WIDTH-1:0] result_q;
  logic [3:0]       rd_q;
  logic             we_q;
  logic             undef_q;
  logic [3:0]       flags_q;
  logic             cond_pass;
  logic [3:0]       exec_flags;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mplier_q;
  logic [4:0]       cnt_q;
`endif

  cond_check u_cond (
    .cond  (reqCond),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  always_comb begin
    aluA      = '0;
    aluB      = '0;
    aluOpCode = ALU_IDLE;
    case (state_q)
      ST_EXEC: begin
        aluA      = opa_q;
        aluB      = opb_q;
        aluOpCode = map_op(op_q);
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        aluA      = opa_q;
        aluB      = mplier_q[0] ? opb_q : '0;
        aluOpCode = ALU_ADD;
      end
`endif
      default: ;
    endcase
  end

  // Z is derived from the result here; the ALU's own zero output is not trusted.
  always_comb begin
    exec_flags    = flags_q;
    exec_flags[3] = aluOut[WIDTH-1];
    exec_flags[2] = (aluOut == '0);
    if (is_arith(op_q)) begin
      exec_flags[1] = aluC;
      exec_flags[0] = aluV;
    end else begin
      exec_flags[1] = shc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      s_q      <= 1'b0;
      shc_q    <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      undef_q  <= 1'b0;
      flags_q  <= '0;
`ifdef ALU_SEQ_MUL_EN
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (reqValid) begin
            op_q     <= reqOp;
            s_q      <= reqS;
            shc_q    <= reqShC;
            rd_q     <= reqRd;
            opa_q    <= reqA;
            opb_q    <= reqB;
            result_q <= '0;
            we_q     <= 1'b0;
            undef_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mplier_q <= reqB;
            cnt_q    <= '0;
            if (!cond_pass) begin
              state_q <= ST_DONE;
            end else if (reqMul) begin
              opa_q   <= '0;
              opb_q   <= reqA;
              state_q <= ST_MUL;
            end else begin
              state_q <= ST_EXEC;
            end
`else
            if (reqMul) begin
              undef_q <= 1'b1;
              state_q <= ST_DONE;
            end else if (!cond_pass) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_EXEC;
            end
`endif
          end
        end
        ST_EXEC: begin
          result_q <= aluOut;
          we_q     <= !is_test(op_q);
          if (is_test(op_q) || s_q) flags_q <= exec_flags;
          state_q  <= ST_DONE;
        end
`ifdef ALU_SEQ_MUL_EN
        ST_MUL: begin
          opa_q    <= aluOut;
          opb_q    <= opb_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_q <= aluOut;
            we_q     <= 1'b1;
            if (s_q) flags_q[3:2] <= {aluOut[WIDTH-1], (aluOut == '0)};
            state_q  <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (respReady) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign reqReady   = (state_q == ST_IDLE);
  assign respValid  = (state_q == ST_DONE);
  assign respResult = result_q;
  assign respRd     = rd_q;
  assign respWe     = we_q;
  assign respUndef  = undef_q;
  assign flags      = flags_q;
  assign aluCarryIn = flags_q[1];
  assign dbgState   = state_q;

endmodule

// File: tb/tb_alu_dp_sequencer.sv
// Directed bench for alu_dp_sequencer with a behavioural ALU model attached.
// Build with ALU_SEQ_MUL_EN defined to exercise the MUL path.
module tb_alu_dp_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid, reqReady;
  logic [3:0]  reqCond, reqOp, reqRd;
  logic        reqS, reqMul, reqShC;
  logic [31:0] reqA, reqB;
  logic [31:0] aluA, aluB, aluOut;
  logic [4:0]  aluOpCode;
  logic        aluCarryIn, aluC, aluV;
  logic        respValid, respReady, respWe, respUndef;
  logic [31:0] respResult;
  logic [3:0]  respRd, flags;
  logic [1:0]  dbgState;

  int checks = 0;
  int failures = 0;

  alu_dp_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqCond(reqCond), .reqOp(reqOp),
    .reqS(reqS), .reqMul(reqMul), .reqA(reqA), .reqB(reqB), .reqShC(reqShC), .reqRd(reqRd),
    .aluA(aluA), .aluB(aluB), .aluOpCode(aluOpCode), .aluCarryIn(aluCarryIn),
    .aluOut(aluOut), .aluC(aluC), .aluV(aluV),
    .respValid(respValid), .respReady(respReady), .respResult(respResult),
    .respRd(respRd), .respWe(respWe), .respUndef(respUndef), .flags(flags),
    .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: x + y + cin with signed overflow from the operand signs.
  function automatic logic [33:0] add3(input logic [31:0] x, input logic [31:0] y, input logic cin);
    logic [32:0] s;
    logic        ov;
    s  = {1'b0, x} + {1'b0, y} + {32'd0, cin};
    ov = (x[31] == y[31]) && (s[31] != x[31]);
    add3 = {ov, s};
  endfunction

  logic [33:0] alu_s;
  always_comb begin
    alu_s  = '0;
    aluOut = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    case (aluOpCode)
      5'b00000: aluOut = aluA & aluB;
      5'b00001: aluOut = aluA ^ aluB;
      5'b00010: alu_s = add3(aluA, ~aluB, 1'b1);
      5'b00011: alu_s = add3(aluB, ~aluA, 1'b1);
      5'b00100: alu_s = add3(aluA, aluB, 1'b0);
      5'b00101: alu_s = add3(aluA, aluB, aluCarryIn);
      5'b00110: alu_s = add3(aluA, ~aluB, aluCarryIn);
      5'b00111: alu_s = add3(aluB, ~aluA, aluCarryIn);
      5'b01100: aluOut = aluA | aluB;
      5'b01101: aluOut = aluB;
      5'b01110: aluOut = aluA & ~aluB;
      5'b01111: aluOut = ~aluB;
      default: aluOut = '0;
    endcase
    if (aluOpCode inside {5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111}) begin
      aluOut = alu_s[31:0];
      aluC   = alu_s[32];
      aluV   = alu_s[33];
    end
  end

  // Drive one request and consume its accept edge; returns in cycle 1.
  task automatic issue(input logic [3:0] cond, input logic [3:0] op, input logic s,
                       input logic mul, input logic [31:0] a, input logic [31:0] b,
                       input logic shc, input logic [3:0] rd);
    reqCond = cond; reqOp = op; reqS = s; reqMul = mul;
    reqA = a; reqB = b; reqShC = shc; reqRd = rd;
    reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
  endtask

  // Cycle index (accept = cycle 0) at which respValid is first seen, bounded.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!respValid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_resp();
    respReady = 1'b1;
    @(posedge clk); #1;
    respReady = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (reqReady !== 1'b1 || respValid !== 1'b0 || dbgState !== 2'd0) begin
      failures++;
      $display("FAIL reset_hs: reqReady=%b respValid=%b state=%0d want 1 0 0", reqReady, respValid, dbgState);
    end
    checks++;
    if (respResult !== 32'd0 || respRd !== 4'd0 || respWe !== 1'b0 || respUndef !== 1'b0 || flags !== 4'b0000) begin
      failures++;
      $display("FAIL reset_resp: result=%h rd=%h we=%b undef=%b flags=%b want all zero", respResult, respRd, respWe, respUndef, flags);
    end
    checks++;
    if (aluA !== 32'd0 || aluB !== 32'd0 || aluOpCode !== 5'b11111 || aluCarryIn !== 1'b0) begin
      failures++;
      $display("FAIL reset_alu: a=%h b=%h op=%b cin=%b want 0 0 11111 0", aluA, aluB, aluOpCode, aluCarryIn);
    end
  endtask

  task automatic test_adds();
    int lat;
    issue(4'hE, 4'h4, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd2);
    checks++;
    if (aluOpCode !== 5'b00100 || aluA !== 32'hFFFF_FFFF || aluB !== 32'd1 || respValid !== 1'b0) begin
      failures++;
      $display("FAIL adds_exec: op=%b a=%h b=%h valid=%b want 00100 ffffffff 1 0", aluOpCode, aluA, aluB, respValid);
    end
    wait_resp(lat);
    checks++;
    if (lat !== 2 || respResult !== 32'd0 || respWe !== 1'b1 || respRd !== 4'd2 || flags !== 4'b0110) begin
      failures++;
      $display("FAIL adds_resp: lat=%0d result=%h we=%b rd=%h flags=%b want 2 0 1 2 0110", lat, respResult, respWe, respRd, flags);
    end
    release_resp();
  endtask

  task automatic test_cmp_mov();
    int lat;
    issue(4'hE, 4'hA, 1'b0, 1'b0, 32'd5, 32'd5, 1'b0, 4'd1);
    checks++;
    if (aluOpCode !== 5'b00010) begin
      failures++;
      $display("FAIL cmp_opcode: op=%b want 00010", aluOpCode);
    end
    wait_resp(lat);
    checks++;
    if (lat !== 2 || respWe !== 1'b0 || flags !== 4'b0110) begin
      failures++;
      $display("FAIL cmp_resp: lat=%0d we=%b flags=%b want 2 0 0110", lat, respWe, flags);
    end
    release_resp();
    issue(4'h0, 4'hD, 1'b0, 1'b0, 32'd0, 32'h1234, 1'b0, 4'd3);
    wait_resp(lat);
    checks++;
    if (lat !== 2 || respResult !== 32'h1234 || respWe !== 1'b1 || respRd !== 4'd3 || flags !== 4'b0110) begin
      failures++;
      $display("FAIL eq_mov: lat=%0d result=%h we=%b rd=%h flags=%b want 2 1234 1 3 0110", lat, respResult, respWe, respRd, flags);
    end
    release_resp();
    issue(4'h1, 4'hD, 1'b0, 1'b0, 32'd0, 32'h1234, 1'b0, 4'd3);
    wait_resp(lat);
    checks++;
    if (lat !== 1 || respWe !== 1'b0 || respUndef !== 1'b0 || flags !== 4'b0110) begin
      failures++;
      $display("FAIL ne_mov: lat=%0d we=%b undef=%b flags=%b want 1 0 0 0110", lat, respWe, respUndef, flags);
    end
    release_resp();
  endtask

  task automatic test_ands();
    int lat;
    issue(4'hE, 4'h4, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 4'd4);
    wait_resp(lat);
    checks++;
    if (respResult !== 32'h8000_0000 || flags !== 4'b1001) begin
      failures++;
      $display("FAIL adds_ovf: result=%h flags=%b want 80000000 1001", respResult, flags);
    end
    release_resp();
    issue(4'hE, 4'h0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'd5);
    wait_resp(lat);
    checks++;
    if (lat !== 2 || respResult !== 32'h8000_0000 || respWe !== 1'b1 || flags !== 4'b1011) begin
      failures++;
      $display("FAIL ands: lat=%0d result=%h we=%b flags=%b want 2 80000000 1 1011", lat, respResult, respWe, flags);
    end
    release_resp();
  endtask

  task automatic test_mul();
    int lat;
`ifdef ALU_SEQ_MUL_EN
    issue(4'hE, 4'h0, 1'b0, 1'b1, 32'd7, 32'd6, 1'b0, 4'd6);
    checks++;
    if (aluOpCode !== 5'b00100 || dbgState !== 2'd2) begin
      failures++;
      $display("FAIL mul_state: op=%b state=%0d want 00100 2", aluOpCode, dbgState);
    end
    wait_resp(lat);
    checks++;
    if (lat !== 33 || respResult !== 32'd42 || respWe !== 1'b1 || respRd !== 4'd6 || flags !== 4'b1011) begin
      failures++;
      $display("FAIL mul_7x6: lat=%0d result=%0d we=%b rd=%h flags=%b want 33 42 1 6 1011", lat, respResult, respWe, respRd, flags);
    end
    release_resp();
    issue(4'hE, 4'h0, 1'b1, 1'b1, 32'd0, 32'd5, 1'b0, 4'd6);
    wait_resp(lat);
    checks++;
    if (lat !== 33 || respResult !== 32'd0 || flags !== 4'b0111) begin
      failures++;
      $display("FAIL muls_zero: lat=%0d result=%h flags=%b want 33 0 0111", lat, respResult, flags);
    end
    release_resp();
`else
    issue(4'hE, 4'h0, 1'b1, 1'b1, 32'd7, 32'd6, 1'b0, 4'd6);
    wait_resp(lat);
    checks++;
    if (lat !== 1 || respUndef !== 1'b1 || respWe !== 1'b0 || respResult !== 32'd0 || flags !== 4'b1011) begin
      failures++;
      $display("FAIL mul_undef: lat=%0d undef=%b we=%b result=%h flags=%b want 1 1 0 0 1011", lat, respUndef, respWe, respResult, flags);
    end
    release_resp();
    issue(4'h0, 4'h0, 1'b0, 1'b1, 32'd7, 32'd6, 1'b0, 4'd6);
    wait_resp(lat);
    checks++;
    if (lat !== 1 || respUndef !== 1'b1 || respWe !== 1'b0) begin
      failures++;
      $display("FAIL mul_undef_condfail: lat=%0d undef=%b we=%b want 1 1 0", lat, respUndef, respWe);
    end
    release_resp();
`endif
  endtask

  task automatic test_backpressure();
    int lat;
    issue(4'hE, 4'hD, 1'b0, 1'b0, 32'd0, 32'hABCD, 1'b0, 4'd7);
    wait_resp(lat);
    reqCond = 4'hE; reqOp = 4'hD; reqB = 32'd1; reqRd = 4'd9; reqMul = 1'b0;
    reqValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (respValid !== 1'b1 || respResult !== 32'hABCD || respRd !== 4'd7 || respWe !== 1'b1 || reqReady !== 1'b0) begin
        failures++;
        $display("FAIL hold_%0d: valid=%b result=%h rd=%h we=%b ready=%b want 1 abcd 7 1 0", i, respValid, respResult, respRd, respWe, reqReady);
      end
    end
    reqValid = 1'b0;
    release_resp();
    checks++;
    if (reqReady !== 1'b1 || respValid !== 1'b0) begin
      failures++;
      $display("FAIL hold_release: ready=%b valid=%b want 1 0", reqReady, respValid);
    end
    respReady = 1'b1;
    @(posedge clk); #1;
    respReady = 1'b0;
    checks++;
    if (reqReady !== 1'b1 || respValid !== 1'b0 || dbgState !== 2'd0) begin
      failures++;
      $display("FAIL idle_ready_ignored: ready=%b valid=%b state=%0d want 1 0 0", reqReady, respValid, dbgState);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(4'hE, 4'h2, 1'b1, 1'b0, 32'd3, 32'd5, 1'b0, 4'd8);
    wait_resp(lat);
    checks++;
    if (respResult !== 32'hFFFF_FFFE || flags !== 4'b1000) begin
      failures++;
      $display("FAIL subs: result=%h flags=%b want fffffffe 1000", respResult, flags);
    end
    release_resp();
    checks++;
    if (reqReady !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready: ready=%b want 1", reqReady);
    end
    issue(4'hE, 4'h6, 1'b0, 1'b0, 32'd10, 32'd3, 1'b0, 4'd10);
    wait_resp(lat);
    checks++;
    if (lat !== 2 || respResult !== 32'd6 || respWe !== 1'b1 || respRd !== 4'd10 || flags !== 4'b1000) begin
      failures++;
      $display("FAIL sbc: lat=%0d result=%0d we=%b rd=%h flags=%b want 2 6 1 a 1000", lat, respResult, respWe, respRd, flags);
    end
    release_resp();
  endtask

  task automatic test_reset_abort();
`ifdef ALU_SEQ_MUL_EN
    issue(4'hE, 4'h0, 1'b0, 1'b1, 32'd7, 32'd6, 1'b0, 4'd6);
    repeat (9) begin
      @(posedge clk); #1;
    end
`else
    issue(4'hE, 4'h0, 1'b0, 1'b1, 32'd7, 32'd6, 1'b0, 4'd6);
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (dbgState !== 2'd0 || respValid !== 1'b0 || flags !== 4'b0000 || reqReady !== 1'b1 ||
        respUndef !== 1'b0 || aluOpCode !== 5'b11111) begin
      failures++;
      $display("FAIL reset_abort: state=%0d valid=%b flags=%b ready=%b undef=%b op=%b want 0 0 0000 1 0 11111",
               dbgState, respValid, flags, reqReady, respUndef, aluOpCode);
    end
  endtask

  initial begin
    reset = 1'b1; reqValid = 1'b0; respReady = 1'b0;
    reqCond = 4'hE; reqOp = 4'h0; reqS = 1'b0; reqMul = 1'b0;
    reqA = '0; reqB = '0; reqShC = 1'b0; reqRd = '0;
    test_reset();
    test_adds();
    test_cmp_mov();
    test_ands();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
